// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, ALU commands
// and the mux select codes driven towards the datapath.
package multicycle_controller_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // Only arithmetic commands produce meaningful carry/overflow.
  function automatic logic isAddSub(input alu_ctrl_t ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// Condition unit: NZCV flags register, condition evaluation, the per-instruction
// condition latch and the gating of every architectural write enable.
module mc_cond_unit
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_aluFlags,
  input  logic [1:0] i_flagW,
  input  logic       i_latchCond,
  input  logic       i_regW,
  input  logic       i_memW,
  input  logic       i_irW,
  input  logic       i_nextPC,
  input  logic       i_branch,
  input  logic       i_rdIsPc,
  output logic       o_regWrite,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_pcWrite
);

  logic [3:0] r_flags;
  logic       r_condExQ;
  logic       w_condEx;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_pcs;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Cond=1111 is reserved in this core and treated as never-execute.
  always_comb begin
    w_condEx = 1'b0;
    case (i_cond)
      4'b0000: w_condEx = w_z;
      4'b0001: w_condEx = ~w_z;
      4'b0010: w_condEx = w_c;
      4'b0011: w_condEx = ~w_c;
      4'b0100: w_condEx = w_n;
      4'b0101: w_condEx = ~w_n;
      4'b0110: w_condEx = w_v;
      4'b0111: w_condEx = ~w_v;
      4'b1000: w_condEx = w_c & ~w_z;
      4'b1001: w_condEx = ~(w_c & ~w_z);
      4'b1010: w_condEx = (w_n == w_v);
      4'b1011: w_condEx = (w_n != w_v);
      4'b1100: w_condEx = ~w_z & (w_n == w_v);
      4'b1101: w_condEx = ~(~w_z & (w_n == w_v));
      4'b1110: w_condEx = 1'b1;
      default: w_condEx = 1'b0;
    endcase
  end

  // The condition is frozen in DECODE so that a flag-setting execute cannot
  // change whether its own writeback happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_condExQ <= 1'b0;
    end else if (i_latchCond) begin
      r_condExQ <= w_condEx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else begin
      if (i_flagW[1] && r_condExQ) begin
        r_flags[3:2] <= i_aluFlags[3:2];
      end
      if (i_flagW[0] && r_condExQ) begin
        r_flags[1:0] <= i_aluFlags[1:0];
      end
    end
  end

  // Enables drop the instant reset asserts, independent of the clock.
  assign w_pcs      = i_branch | (i_rdIsPc & i_regW);
  assign o_regWrite = rst_n & i_regW & r_condExQ;
  assign o_memWrite = rst_n & i_memW & r_condExQ;
  assign o_irWrite  = rst_n & i_irW;
  assign o_pcWrite  = rst_n & (i_nextPC | (w_pcs & r_condExQ));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute over a
// shared ALU and unified memory, plus the ALU decoder.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [31:12]       Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUControl,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic               RegWrite,
  output logic [STATE_W-1:0] State
);

  state_t    r_state;
  state_t    w_nextState;
  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic       w_unusedRn;
  logic       w_nextPC;
  logic       w_branch;
  logic       w_regW;
  logic       w_memW;
  logic       w_irW;
  logic       w_aluOp;
  logic       w_latchCond;
  logic       w_isCmp;
  alu_ctrl_t  w_aluCmd;
  logic [1:0] w_flagW;

  assign w_cond     = Instr[31:28];
  assign w_op       = Instr[27:26];
  assign w_funct    = Instr[25:20];
  assign w_rd       = Instr[15:12];
  assign w_unusedRn = ^Instr[19:16];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = S_FETCH;
    w_nextPC    = 1'b0;
    w_branch    = 1'b0;
    w_regW      = 1'b0;
    w_memW      = 1'b0;
    w_irW       = 1'b0;
    w_aluOp     = 1'b0;
    w_latchCond = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_WDATA;
    case (r_state)
      S_FETCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        w_irW       = 1'b1;
        w_nextPC    = 1'b1;
        w_nextState = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        w_latchCond = 1'b1;
        case (w_op)
          OP_MEM:  w_nextState = S_MEMADR;
          OP_DP:   w_nextState = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   w_nextState = S_BRANCH;
          default: w_nextState = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB     = SRCB_IMM;
        w_nextState = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc      = 1'b1;
        w_nextState = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_regW      = 1'b1;
        w_nextState = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_memW      = 1'b1;
        w_nextState = S_FETCH;
      end
      S_EXECUTER: begin
        w_aluOp     = 1'b1;
        w_nextState = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB     = SRCB_IMM;
        w_aluOp     = 1'b1;
        w_nextState = S_ALUWB;
      end
      S_ALUWB: begin
        w_regW      = ~w_isCmp;
        w_nextState = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB     = SRCB_IMM;
        ResultSrc   = RES_ALURESULT;
        w_branch    = 1'b1;
        w_nextState = S_FETCH;
      end
      default: w_nextState = S_FETCH;
    endcase
  end

  // CMP is decoded independently of ALUOp because its write suppression is
  // needed in ALUWB, after ALUOp has already dropped.
  always_comb begin
    w_aluCmd = ALU_ADD;
    w_isCmp  = 1'b0;
    case (w_funct[4:1])
      CMD_ADD: w_aluCmd = ALU_ADD;
      CMD_SUB: w_aluCmd = ALU_SUB;
      CMD_AND: w_aluCmd = ALU_AND;
      CMD_ORR: w_aluCmd = ALU_ORR;
      CMD_CMP: begin
        w_aluCmd = ALU_SUB;
        w_isCmp  = 1'b1;
      end
      default: w_aluCmd = ALU_ADD;
    endcase
  end

  assign ALUControl = w_aluOp ? w_aluCmd : ALU_ADD;
  assign w_flagW[1] = w_aluOp & w_funct[0];
  assign w_flagW[0] = w_flagW[1] & isAddSub(w_aluCmd);

  assign ImmSrc = w_op;
  assign RegSrc = {(w_op == OP_MEM), (w_op == OP_BR)};
  assign State  = STATE_W'(r_state);

  mc_cond_unit u_cond (
    .clk         (clk),
    .rst_n       (Reset),
    .i_cond      (w_cond),
    .i_aluFlags  (ALUFlags),
    .i_flagW     (w_flagW),
    .i_latchCond (w_latchCond),
    .i_regW      (w_regW),
    .i_memW      (w_memW),
    .i_irW       (w_irW),
    .i_nextPC    (w_nextPC),
    .i_branch    (w_branch),
    .i_rdIsPc    (w_rd == 4'hF),
    .o_regWrite  (RegWrite),
    .o_memWrite  (MemWrite),
    .o_irWrite   (IRWrite),
    .o_pcWrite   (PCWrite)
  );

endmodule
